// File: rtl/rtr_channel_output_pkg.sv
// Shared constants and helpers for the router channel transmit side.
package rtr_channel_output_pkg;

  localparam int PACKET_FORMAT_HEAD_TAIL       = 0;
  localparam int PACKET_FORMAT_TAIL_ONLY       = 1;
  localparam int PACKET_FORMAT_EXPLICIT_LENGTH = 2;

  localparam int RESET_TYPE_ASYNC = 0;
  localparam int RESET_TYPE_SYNC  = 1;

  // Ceiling log2; returns 0 for n <= 1 so a single-VC channel carries no index.
  function automatic int clogb(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rtr_channel_frame_check.sv
// Per-VC packet framing tracker: flags heads inside a packet and
// body/tail flits outside one. The error flop lines up with the s2 stage.
module rtr_channel_frame_check
  import rtr_channel_output_pkg::*;
#(
  parameter int num_vcs       = 4,
  parameter int packet_format = PACKET_FORMAT_EXPLICIT_LENGTH,
  parameter int vc_w          = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            active,
  input  logic            flit_valid,
  input  logic            flit_head,
  input  logic            flit_tail,
  input  logic [vc_w-1:0] flit_vc,
  output logic            error_out
);

  logic [num_vcs-1:0] in_pkt_d, in_pkt_q;
  logic               err_d, err_q;
  logic               cur_in_pkt;

  // Next-state for the in-packet flags and the error pulse.
  always_comb begin
    in_pkt_d   = in_pkt_q;
    err_d      = err_q;
    cur_in_pkt = in_pkt_q[flit_vc];
    if (active) begin
      err_d = 1'b0;
      if (flit_valid) begin
        if (packet_format == PACKET_FORMAT_TAIL_ONLY) begin
          // Head is implied by an idle VC, so only the tail moves the flag.
          in_pkt_d[flit_vc] = ~flit_tail;
        end else if (flit_head) begin
          err_d             = cur_in_pkt;
          in_pkt_d[flit_vc] = ~flit_tail;
        end else begin
          err_d = ~cur_in_pkt;
          if (flit_tail) in_pkt_d[flit_vc] = 1'b0;
        end
      end
    end
  end

  // Framing state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_pkt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      in_pkt_q <= in_pkt_d;
      err_q    <= err_d;
    end
  end

  assign error_out = err_q;

endmodule

// File: rtl/rtr_channel_output.sv
// Router channel transmitter: two-stage pipeline packing flits onto the
// channel bus, with an early/held link-active bit and framing checks.
// Bus layout from bit 0 upward: [link] [valid] [vc_idx] [flags] [data].
module rtr_channel_output
  import rtr_channel_output_pkg::*;
#(
  parameter int num_vcs          = 4,
  parameter int packet_format    = PACKET_FORMAT_EXPLICIT_LENGTH,
  parameter int enable_link_pm   = 1,
  parameter int link_hold_cycles = 2,
  parameter int flit_data_width  = 64,
  parameter int reset_type       = RESET_TYPE_ASYNC,
  localparam int vc_idx_width    = clogb(num_vcs),
  localparam int flit_ctrl_width = (packet_format == PACKET_FORMAT_HEAD_TAIL) ?
                                   (1 + vc_idx_width + 2) : (1 + vc_idx_width + 1),
  localparam int channel_width   = enable_link_pm + flit_ctrl_width + flit_data_width
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       active,
  input  logic                       flit_valid_in,
  input  logic                       flit_head_in,
  input  logic                       flit_tail_in,
  input  logic [num_vcs-1:0]         flit_sel_in_ovc,
  input  logic [flit_data_width-1:0] flit_data_in,
  output logic [channel_width-1:0]   channel_out,
  output logic                       error_out
);

  localparam int VC_W      = (vc_idx_width > 0) ? vc_idx_width : 1;
  localparam int FLAG_W    = flit_ctrl_width - 1 - vc_idx_width;
  localparam int VALID_POS = enable_link_pm;
  localparam int VC_POS    = VALID_POS + 1;
  localparam int FLAG_POS  = VC_POS + vc_idx_width;
  localparam int DATA_POS  = FLAG_POS + FLAG_W;

  logic [VC_W-1:0]            sel_bin;
  logic                       s1_vld_d, s1_vld_q;
  logic                       s1_head_d, s1_head_q;
  logic                       s1_tail_d, s1_tail_q;
  logic [VC_W-1:0]            s1_vc_d, s1_vc_q;
  logic [flit_data_width-1:0] s1_data_d, s1_data_q;
  logic [FLAG_W-1:0]          s1_flags;
  logic                       s2_vld_d, s2_vld_q;
  logic [VC_W-1:0]            s2_vc_d, s2_vc_q;
  logic [FLAG_W-1:0]          s2_flags_d, s2_flags_q;
  logic [flit_data_width-1:0] s2_data_d, s2_data_q;

  // One-hot output-VC select to binary index.
  always_comb begin
    sel_bin = '0;
    for (int i = 0; i < num_vcs; i++) begin
      if (flit_sel_in_ovc[i]) sel_bin = sel_bin | VC_W'(i);
    end
  end

  // s1 input capture: valid follows every active cycle, payload loads only with a flit.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_head_d = s1_head_q;
    s1_tail_d = s1_tail_q;
    s1_vc_d   = s1_vc_q;
    s1_data_d = s1_data_q;
    if (active) begin
      s1_vld_d = flit_valid_in;
      if (flit_valid_in) begin
        s1_head_d = flit_head_in;
        s1_tail_d = flit_tail_in;
        s1_vc_d   = sel_bin;
        s1_data_d = flit_data_in;
      end
    end
  end

  // Control field carried on the channel depends on the packet format.
  if (packet_format == PACKET_FORMAT_HEAD_TAIL) begin : g_flags_ht
    assign s1_flags = {s1_tail_q, s1_head_q};
  end else if (packet_format == PACKET_FORMAT_TAIL_ONLY) begin : g_flags_t
    assign s1_flags = s1_tail_q;
  end else begin : g_flags_h
    assign s1_flags = s1_head_q;
  end

  // s2 channel stage: same load policy, fed from s1.
  always_comb begin
    s2_vld_d   = s2_vld_q;
    s2_vc_d    = s2_vc_q;
    s2_flags_d = s2_flags_q;
    s2_data_d  = s2_data_q;
    if (active) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_vc_d    = s1_vc_q;
        s2_flags_d = s1_flags;
        s2_data_d  = s1_data_q;
      end
    end
  end

  // Valid bits of both stages; reset drops any flit in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

  // Payload and control-field registers, unreset (don't-care while valid is low).
  always_ff @(posedge clk) begin
    s1_head_q  <= s1_head_d;
    s1_tail_q  <= s1_tail_d;
    s1_vc_q    <= s1_vc_d;
    s1_data_q  <= s1_data_d;
    s2_vc_q    <= s2_vc_d;
    s2_flags_q <= s2_flags_d;
    s2_data_q  <= s2_data_d;
  end

  if (enable_link_pm != 0) begin : g_link
    logic       link_d, link_q;
    logic [3:0] hold_ctr_d, hold_ctr_q;

    // Link rises one cycle ahead of the first flit and stays up through the idle hold.
    always_comb begin
      link_d     = link_q;
      hold_ctr_d = hold_ctr_q;
      if (active) begin
        link_d = flit_valid_in | s1_vld_q | s2_vld_q | (hold_ctr_q != 4'd0);
        if (s2_vld_q) hold_ctr_d = 4'(link_hold_cycles);
        else if (hold_ctr_q != 4'd0) hold_ctr_d = hold_ctr_q - 4'd1;
      end
    end

    // Link and hold counter registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        link_q     <= 1'b0;
        hold_ctr_q <= 4'd0;
      end else begin
        link_q     <= link_d;
        hold_ctr_q <= hold_ctr_d;
      end
    end

    assign channel_out[0] = link_q;
  end

  assign channel_out[VALID_POS] = s2_vld_q;

  if (vc_idx_width > 0) begin : g_vc
    assign channel_out[VC_POS +: VC_W] = s2_vc_q;
  end

  assign channel_out[FLAG_POS +: FLAG_W]          = s2_flags_q;
  assign channel_out[DATA_POS +: flit_data_width] = s2_data_q;

  rtr_channel_frame_check #(
    .num_vcs      (num_vcs),
    .packet_format(packet_format),
    .vc_w         (VC_W)
  ) u_frame_check (
    .clk       (clk),
    .reset     (reset),
    .active    (active),
    .flit_valid(s1_vld_q),
    .flit_head (s1_head_q),
    .flit_tail (s1_tail_q),
    .flit_vc   (s1_vc_q),
    .error_out (error_out)
  );

endmodule
